pong_controller: RTL and testbench
==================================

// Module: pong_controller
// PURPOSE
//   Game-flow FSM for the 8-LED Pong game. Moves a one-hot ball across out[7:0]
//   one position per Clk (Clk is the slow game tick produced upstream).
//   Checks each player's paddle button when the ball reaches that player's end.
//   Drives control strobes to the hit counter, the level logic and the 5 s / 20 s timers.
// PARAMETERS
//   none (LED width fixed at 8)
// PORTS
//   Clk      in   1  game clock; all state changes on rising edge
//   Rst      in   1  synchronous reset, active-low (Rst==0 at posedge -> reset)
//   b        in   1  left player button (out[7] end); also serves
//   p        in   1  right player button (out[0] end)
//   T5_in    in   1  5 s timer expired
//   out      out  8  LED pattern: one-hot ball position, or 8'hFF after a miss
//   T5_en    out  1  enable 5 s timer (miss display period)
//   T20_en   out  1  enable 20 s level timer (high during rally)
//   Hit_ld   out  1  one-cycle pulse: successful return, increment hit counter
//   Hit_clr  out  1  clear hit counter
//   Lvl_clr  out  1  clear level logic
// BEHAVIOUR
//   - All outputs registered; out and strobes update on the same edge as the state.
//   - Inputs are level-sampled at posedge, with no edge detection.
//   - Buttons are checked only in the cycle the ball sits at that player's end.
//   - States: IDLE, MOVE_R, MOVE_L, MISS.
//   - Reset (any state, Rst==0): state=IDLE, out=8'h80, Hit_clr=1, Lvl_clr=1,
//     T5_en=0, T20_en=0, Hit_ld=0.
//   - IDLE: out=8'h80, Hit_clr=Lvl_clr=1, other strobes 0.
//     b==1 -> MOVE_R with out=8'h40. Otherwise stay.
//   - MOVE_R: T20_en=1, Hit_clr=Lvl_clr=0.
//     If out!=8'h01, then out<=out>>1.
//     If out==8'h01 and p==1: out<=8'h02, Hit_ld=1 for exactly that next cycle, -> MOVE_L.
//     If out==8'h01 and p==0: out<=8'hFF, -> MISS.
//   - MOVE_L: mirror of MOVE_R.
//     If out!=8'h80, then out<=out<<1.
//     At out==8'h80: b==1 -> out<=8'h40, Hit_ld pulse, -> MOVE_R; else out<=8'hFF, -> MISS.
//   - MISS: out=8'hFF, T5_en=1, T20_en=0.
//     T5_in==1 -> IDLE (out=8'h80, Hit_clr=Lvl_clr=1, T5_en=0). Otherwise stay.
//   - Ball travel: serve to right end = 7 edges; end to end = 7 edges.
//   - Ignored inputs:
//     - Button presses away from the player's end position.
//     - The opposing player's button.
//     - T5_in outside MISS.
//     - b while in MISS.
//   - Simultaneous b and p: only the button owning the current end is evaluated.
//   - Hit_ld never asserted for 2 consecutive cycles.
//   - Hit_clr/Lvl_clr are held high for the whole IDLE stay.
//   - Reset mid-rally or in MISS returns to IDLE on the next edge, with no Hit_ld.
//   - out always one-hot, except 8'hFF in MISS.
// TESTING
//   - Reset: Rst=0 for 3 edges -> out=8'h80, Hit_clr=Lvl_clr=1, T5_en=T20_en=Hit_ld=0.
//   - Serve: b=1 one edge in IDLE -> out 40,20,10,08,04,02,01 on successive edges; T20_en=1.
//   - Miss right: p=0 while out==8'h01 -> next out=8'hFF, T5_en=1, T20_en=0; holds until T5_in.
//   - Timeout: T5_in=1 for one edge in MISS -> IDLE, out=8'h80, Hit_clr=Lvl_clr=1, T5_en=0.
//   - Return right: p=1 exactly when out==8'h01 -> out=8'h02, Hit_ld=1 one cycle, then 04,08,...
//   - Early/late press: p pulsed when out==8'h04 -> ignored, miss results.
//     Rst=0 mid-rally -> IDLE next edge.

Source files
------------

// File: rtl/pong_controller.sv
// rtl/pong_controller.sv - game-flow FSM for the 8-LED Pong game
// Moves a one-hot ball across out[7:0] one step per Clk, checks paddles at each end, drives timer/counter strobes.
module pong_controller (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       b,
  input  logic       p,
  input  logic       T5_in,
  output logic [7:0] out,
  output logic       T5_en,
  output logic       T20_en,
  output logic       Hit_ld,
  output logic       Hit_clr,
  output logic       Lvl_clr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_R = 2'd1,
    MOVE_L = 2'd2,
    MISS   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] out_q, out_d;
  logic       hit_ld_q, hit_ld_d;
  logic       t5_en_q, t5_en_d;
  logic       t20_en_q, t20_en_d;
  logic       clr_q, clr_d;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    hit_ld_d = 1'b0;
    case (state_q)
      IDLE: begin
        out_d = 8'h80;
        if (b) begin
          state_d = MOVE_R;
          out_d   = 8'h40;
        end
      end
      MOVE_R: begin
        // only p is looked at, and only while the ball sits at the right end
        if (out_q != 8'h01) begin
          out_d = out_q >> 1;
        end else if (p) begin
          out_d    = 8'h02;
          hit_ld_d = 1'b1;
          state_d  = MOVE_L;
        end else begin
          out_d   = 8'hFF;
          state_d = MISS;
        end
      end
      MOVE_L: begin
        if (out_q != 8'h80) begin
          out_d = out_q << 1;
        end else if (b) begin
          out_d    = 8'h40;
          hit_ld_d = 1'b1;
          state_d  = MOVE_R;
        end else begin
          out_d   = 8'hFF;
          state_d = MISS;
        end
      end
      MISS: begin
        out_d = 8'hFF;
        if (T5_in) begin
          state_d = IDLE;
          out_d   = 8'h80;
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = 8'h80;
      end
    endcase

    // strobes are registered alongside the state they belong to
    t5_en_d  = (state_d == MISS);
    t20_en_d = (state_d == MOVE_R) || (state_d == MOVE_L);
    clr_d    = (state_d == IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= IDLE;
      out_q    <= 8'h80;
      hit_ld_q <= 1'b0;
      t5_en_q  <= 1'b0;
      t20_en_q <= 1'b0;
      clr_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      hit_ld_q <= hit_ld_d;
      t5_en_q  <= t5_en_d;
      t20_en_q <= t20_en_d;
      clr_q    <= clr_d;
    end
  end

  assign out     = out_q;
  assign T5_en   = t5_en_q;
  assign T20_en  = t20_en_q;
  assign Hit_ld  = hit_ld_q;
  assign Hit_clr = clr_q;
  assign Lvl_clr = clr_q;

endmodule

// File: tb/tb_pong_controller.sv
// tb/tb_pong_controller.sv - randomized self-checking bench for pong_controller
// Reference model tracks the ball as an integer position and direction.
module tb_pong_controller;

  logic       Clk = 1'b0;
  logic       Rst, b, p, T5_in;
  logic [7:0] out;
  logic       T5_en, T20_en, Hit_ld, Hit_clr, Lvl_clr;

  pong_controller dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .b      (b),
    .p      (p),
    .T5_in  (T5_in),
    .out    (out),
    .T5_en  (T5_en),
    .T20_en (T20_en),
    .Hit_ld (Hit_ld),
    .Hit_clr(Hit_clr),
    .Lvl_clr(Lvl_clr)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // model: mode 0=idle 1=rally 2=miss; pos 7..0 (7 = out[7] end); dir -1 right, +1 left
  int m_mode, m_pos, m_dir;
  bit m_hit, m_hit_prev;

  task automatic model_step(input bit rst, input bit bb, input bit pp, input bit t5);
    m_hit_prev = m_hit;
    m_hit = 1'b0;
    if (!rst) begin
      m_mode = 0; m_pos = 7; m_dir = -1;
    end else begin
      case (m_mode)
        0: if (bb) begin m_mode = 1; m_dir = -1; m_pos = 6; end
        1: begin
          if (m_pos != ((m_dir < 0) ? 0 : 7)) m_pos += m_dir;
          else if ((m_dir < 0) ? pp : bb) begin
            m_dir = -m_dir; m_pos += m_dir; m_hit = 1'b1;
          end else m_mode = 2;
        end
        default: if (t5) begin m_mode = 0; m_pos = 7; end
      endcase
    end
  endtask

  task automatic check_all(input string ctx);
    logic [7:0] exp_out;
    exp_out = (m_mode == 2) ? 8'hFF : (8'h01 << m_pos);
    chk({ctx, ":out"},     out,            exp_out);
    chk({ctx, ":T5_en"},   {7'd0, T5_en},  {7'd0, m_mode == 2});
    chk({ctx, ":T20_en"},  {7'd0, T20_en}, {7'd0, m_mode == 1});
    chk({ctx, ":Hit_ld"},  {7'd0, Hit_ld}, {7'd0, m_hit});
    chk({ctx, ":Hit_clr"}, {7'd0, Hit_clr},{7'd0, m_mode == 0});
    chk({ctx, ":Lvl_clr"}, {7'd0, Lvl_clr},{7'd0, m_mode == 0});
    if (m_hit_prev) chk({ctx, ":hit_twice"}, {7'd0, Hit_ld & m_hit_prev}, 8'd0);
  endtask

  task automatic cycle(input bit rst, input bit bb, input bit pp, input bit t5, input string ctx);
    @(negedge Clk);
    Rst = rst; b = bb; p = pp; T5_in = t5;
    @(posedge Clk);
    model_step(rst, bb, pp, t5);
    #1;
    check_all(ctx);
  endtask

  initial begin
    bit at_end, bb, pp, t5, rr;
    Rst = 1'b0; b = 1'b0; p = 1'b0; T5_in = 1'b0;
    m_mode = 0; m_pos = 7; m_dir = -1; m_hit = 0; m_hit_prev = 0;

    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, "reset");

    // serve, full right run, return, full left run, miss on left, timeout
    cycle(1'b1, 1'b1, 1'b0, 1'b1, "serve");
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, "travel_r");
    cycle(1'b1, 1'b1, 1'b1, 1'b0, "return_r");
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1, "travel_l");
    cycle(1'b1, 1'b0, 1'b1, 1'b1, "miss_l");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, "miss_hold");
    cycle(1'b1, 1'b0, 1'b0, 1'b1, "timeout");

    // early press at out==04 then miss on right, then reset mid-rally
    cycle(1'b1, 1'b1, 1'b0, 1'b0, "serve2");
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, (m_pos == 2), 1'b0, "early_p");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, "miss_r");
    cycle(1'b1, 1'b1, 1'b0, 1'b1, "timeout2");
    cycle(1'b1, 1'b1, 1'b0, 1'b0, "serve3");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, "rally");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, "rst_mid");

    for (int i = 0; i < 3000; i++) begin
      at_end = (m_mode == 1) && (m_pos == ((m_dir < 0) ? 0 : 7));
      rr = ($urandom_range(99) >= 2);
      bb = at_end ? ($urandom_range(99) < 75) : $urandom_range(1);
      pp = at_end ? ($urandom_range(99) < 75) : $urandom_range(1);
      t5 = ($urandom_range(99) < 25);
      cycle(rr, bb, pp, t5, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
